// File: rtl/scan_pkg.sv
// Shared definitions for the scan chain sequencer: state encoding and default sizes.
package scan_pkg;

    localparam int CHAIN_LEN_DEF = 8;
    localparam int CNT_W_DEF     = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CAPTURE = 2'd2,
        FINISH  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/scan_chain_ctrl_if.sv
// Request/response and chain-facing signals of the scan chain sequencer.
interface scan_chain_ctrl_if #(
    parameter int CHAIN_LEN = 8
);
    import scan_pkg::*;

    // Handshake: START is taken only while the sequencer is idle (BUSY low and no
    // operation starting). BUSY rises the cycle after acceptance and stays high
    // until the cycle in which the single-cycle DONE pulse is shown. A START seen
    // while BUSY is high is dropped, not queued.
    logic                 START;
    logic [CHAIN_LEN-1:0] PAT_IN;
    logic                 CAPTURE_EN;
    logic                 SCANOUT;
    logic                 TEST;
    logic                 SCANIN;
    logic                 BUSY;
    logic                 DONE;
    logic [CHAIN_LEN-1:0] RESULT;
    logic                 RESULT_PAR;
    scan_state_t          STATE;

    modport master (
        output START, PAT_IN, CAPTURE_EN, SCANOUT,
        input  TEST, SCANIN, BUSY, DONE, RESULT, RESULT_PAR, STATE
    );

    modport slave (
        input  START, PAT_IN, CAPTURE_EN, SCANOUT,
        output TEST, SCANIN, BUSY, DONE, RESULT, RESULT_PAR, STATE
    );

endinterface

// File: rtl/scan_shreg.sv
// Parallel-load, left-shifting register; serial data enters at the LSB, leaves at the MSB.
module scan_shreg #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         shift,
    input  logic         sin,
    output logic [W-1:0] q
);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= {q[W-2:0], sin};
        end
    end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: shifts a pattern in MSB-first, collects the old chain contents,
// optionally captures once. Optional RESULT_PAR generation under SCAN_RESULT_PARITY_EN.
module scan_chain_ctrl
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    scan_chain_ctrl_if.slave  bus
);

    scan_state_t          state;
    logic [CNT_W-1:0]     cnt;
    logic                 cap_q;
    logic                 test_q;
    logic                 scanin_q;
    logic                 busy_q;
    logic                 done_q;
    logic [CHAIN_LEN-1:0] pat_q;
    logic [CHAIN_LEN-1:0] result_q;
    logic                 accept;
    logic                 shifting;
    logic                 last_shift;
    logic                 pat_low_unused;

    assign accept     = (state == IDLE) && bus.START;
    assign shifting   = (state == SHIFT);
    assign last_shift = shifting && (cnt == CNT_W'(CHAIN_LEN - 1));

    // The MSB goes straight to SCANIN on the accepting edge, so the pattern
    // register is preloaded with the remaining bits already moved up one place.
    scan_shreg #(.W(CHAIN_LEN)) u_pat (
        .CLK      (CLK),
        .RESET    (RESET),
        .load     (accept),
        .load_val ({bus.PAT_IN[CHAIN_LEN-2:0], 1'b0}),
        .shift    (shifting),
        .sin      (1'b0),
        .q        (pat_q)
    );

    scan_shreg #(.W(CHAIN_LEN)) u_result (
        .CLK      (CLK),
        .RESET    (RESET),
        .load     (accept),
        .load_val ('0),
        .shift    (shifting),
        .sin      (bus.SCANOUT),
        .q        (result_q)
    );

    assign pat_low_unused = ^pat_q[CHAIN_LEN-2:0];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            cnt      <= '0;
            cap_q    <= 1'b0;
            test_q   <= 1'b0;
            scanin_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        state    <= SHIFT;
                        cnt      <= '0;
                        cap_q    <= bus.CAPTURE_EN;
                        test_q   <= 1'b1;
                        scanin_q <= bus.PAT_IN[CHAIN_LEN-1];
                        busy_q   <= 1'b1;
                    end
                end
                SHIFT: begin
                    cnt <= cnt + 1'b1;
                    if (last_shift) begin
                        test_q   <= 1'b0;
                        scanin_q <= 1'b0;
                        if (cap_q) begin
                            state <= CAPTURE;
                        end else begin
                            state  <= FINISH;
                            done_q <= 1'b1;
                        end
                    end else begin
                        scanin_q <= pat_q[CHAIN_LEN-1];
                    end
                end
                CAPTURE: begin
                    // TEST is already low, so the chain takes its functional D inputs here.
                    state  <= FINISH;
                    done_q <= 1'b1;
                end
                FINISH: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.TEST   = test_q;
    assign bus.SCANIN = scanin_q;
    assign bus.BUSY   = busy_q;
    assign bus.DONE   = done_q;
    assign bus.RESULT = result_q;
    assign bus.STATE  = state;

`ifdef SCAN_RESULT_PARITY_EN
    logic par_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= 1'b0;
        end else if (state == FINISH) begin
            par_q <= ^result_q;
        end
    end

    assign bus.RESULT_PAR = par_q;
`else
    assign bus.RESULT_PAR = 1'b0;
`endif

endmodule
